// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle,
// with a single sign-fix cycle before the result is published.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alu_opt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0]      OP_MUL     = 2'd0;
  localparam logic [1:0]      OP_MULH    = 2'd1;
  localparam logic [1:0]      OP_DIV     = 2'd2;
  localparam logic [1:0]      OP_REM     = 2'd3;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rawA_q;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] accHi_q;
  logic [WIDTH-1:0] accLo_q;
  logic [CW-1:0]    count_q;
  logic             negRes_q;
  logic             negRem_q;
  logic             divZero_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             opValid;
  logic             accept;
  logic             isSigned;
  logic             divOp;
  logic             signA;
  logic             signB;
  logic             bZero;
  logic             ovfIn;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  always_comb begin
    opValid  = (alu_opt[4:2] == 3'b010);
    accept   = start && opValid && ((state_q == IDLE) || (state_q == DONE));
    isSigned = (alu_opt[1:0] != OP_MUL);
    divOp    = alu_opt[1];
    signA    = isSigned && a[WIDTH-1];
    signB    = isSigned && b[WIDTH-1];
    magA     = signA ? -a : a;
    magB     = signB ? -b : b;
    bZero    = (b == '0);
    ovfIn    = (a == MOST_NEG) && (b == '1);
  end

  // accHi/accLo hold the running product, or the partial remainder and shifting quotient.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divRem;
  logic             divFits;
  logic [WIDTH-1:0] divTrial;
  logic [WIDTH-1:0] stepHi_d;
  logic [WIDTH-1:0] stepLo_d;

  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operand_q} : '0);
    divRem   = {accHi_q, accLo_q[WIDTH-1]};
    divFits  = (divRem >= {1'b0, operand_q});
    divTrial = divRem[WIDTH-1:0] - operand_q;
    if (op_q[1]) begin
      stepHi_d = divFits ? divTrial : divRem[WIDTH-1:0];
      stepLo_d = {accLo_q[WIDTH-2:0], divFits};
    end else begin
      stepHi_d = mulSum[WIDTH:1];
      stepLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] productFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
  logic [WIDTH-1:0]   fixResult_d;

  always_comb begin
    productFix  = negRes_q ? -{accHi_q, accLo_q} : {accHi_q, accLo_q};
    quotFix     = negRes_q ? -accLo_q : accLo_q;
    remFix      = negRem_q ? -accHi_q : accHi_q;
    fixResult_d = '0;
    case (op_q)
      OP_MUL:  fixResult_d = productFix[WIDTH-1:0];
      OP_MULH: fixResult_d = productFix[2*WIDTH-1:WIDTH];
      OP_DIV:  fixResult_d = divZero_q ? '1 : (ovf_q ? rawA_q : quotFix);
      OP_REM:  fixResult_d = divZero_q ? rawA_q : (ovf_q ? '0 : remFix);
    endcase
  end

  // Divide-by-zero and signed overflow bypass CALC and resolve entirely in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      rawA_q    <= '0;
      operand_q <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      count_q   <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            op_q      <= alu_opt[1:0];
            rawA_q    <= a;
            negRes_q  <= signA ^ signB;
            negRem_q  <= signA;
            divZero_q <= divOp && bZero;
            ovf_q     <= divOp && ovfIn;
            count_q   <= '0;
            accHi_q   <= '0;
            operand_q <= divOp ? magB : magA;
            accLo_q   <= divOp ? magA : magB;
            busy_q    <= 1'b1;
            state_q   <= (divOp && (bZero || ovfIn)) ? FIX : CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          accHi_q <= stepHi_d;
          accLo_q <= stepLo_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fixResult_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  alu_opt;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int testsRun    = 0;
  int testsFailed = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alu_opt (alu_opt),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed/unsigned 64-bit arithmetic, SV division truncates toward zero.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sx;
    longint          sy;
    longint unsigned ux;
    longint unsigned uy;
    logic [63:0]     p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      2'd0: begin p = ux * uy; return p[31:0]; end
      2'd1: begin p = sx * sy; return p[63:32]; end
      2'd2: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == MOST_NEG && y == 32'hFFFF_FFFF) return x;
        p = sx / sy;
        return p[31:0];
      end
      default: begin
        if (y == 32'd0) return x;
        if (x == MOST_NEG && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] x,
                                     input logic [31:0] y);
    if (op[1] && (y == 32'd0 || (x == MOST_NEG && y == 32'hFFFF_FFFF))) return 2;
    return 34;
  endfunction

  // Called at a negedge: the following rising edge is edge 0.
  task automatic issue_op(input logic [4:0] op, input logic [31:0] opA, input logic [31:0] opB);
    start   = 1'b1;
    alu_opt = op;
    a       = opA;
    b       = opB;
    @(posedge clk);
    #1;
    start   = 1'b0;
    a       = $urandom;
    b       = $urandom;
    alu_opt = 5'($urandom);
  endtask

  // Samples at negedge k (just before edge k); scrambles inputs and fires stray starts while busy.
  task automatic wait_done(input int budget, input int injectAt, output int doneEdge,
                           output int busyCount, output logic busyAtDone);
    doneEdge   = 0;
    busyCount  = 0;
    busyAtDone = 1'bx;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCount++;
      if (done === 1'b1) begin
        doneEdge   = k;
        busyAtDone = busy;
        break;
      end
      if (k == injectAt) begin
        start   = 1'b1;
        alu_opt = 5'd8;
        a       = 32'd3;
        b       = 32'd3;
      end else begin
        a       = $urandom;
        b       = $urandom;
        alu_opt = 5'($urandom_range(8, 11));
        start   = (busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    testsRun++;
    if ({busy, done} !== 2'b00 || result !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b result=%h, expected 0 0 00000000",
               busy, done, result);
    end
    repeat (2) @(negedge clk);
    testsRun++;
    if ({busy, done} !== 2'b00 || result !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_hold: busy=%b done=%b result=%h, expected 0 0 00000000",
               busy, done, result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_invalid_op();
    logic [4:0] badOps [3] = '{5'd7, 5'd12, 5'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start   = 1'b1;
      alu_opt = badOps[i];
      a       = 32'd9;
      b       = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      testsRun++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL invalid_op_%0d: busy=%b done=%b, expected 0 0", badOps[i], busy, done);
      end
    end
  endtask

  task automatic test_mul_basic();
    int   doneEdge;
    int   busyCount;
    logic busyAtDone;
    @(negedge clk);
    issue_op(5'd8, 32'd6, 32'd5);
    wait_done(40, 0, doneEdge, busyCount, busyAtDone);
    testsRun++;
    if (doneEdge !== 34) begin
      testsFailed++;
      $display("[TB] FAIL mul_latency: done at edge %0d, expected 34", doneEdge);
    end
    testsRun++;
    if (busyCount !== 33 || busyAtDone !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mul_busy: busy cycles %0d busy_at_done %b, expected 33 0",
               busyCount, busyAtDone);
    end
    testsRun++;
    if (result !== 32'd30) begin
      testsFailed++;
      $display("[TB] FAIL mul_result: got %h, expected %h", result, 32'd30);
    end
    @(negedge clk);
    testsRun++;
    if (done !== 1'b0 || result !== 32'd30) begin
      testsFailed++;
      $display("[TB] FAIL mul_hold: done=%b result=%h, expected 0 %h", done, result, 32'd30);
    end
  endtask

  task automatic test_mulh();
    logic [31:0] xs   [2] = '{32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] ys   [2] = '{32'd4, 32'hFFFF_FFFF};
    logic [31:0] exps [2] = '{32'hFFFF_FFFE, 32'h0000_0000};
    int   doneEdge;
    int   busyCount;
    logic busyAtDone;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue_op(5'd9, xs[i], ys[i]);
      wait_done(40, 0, doneEdge, busyCount, busyAtDone);
      testsRun++;
      if (doneEdge !== 34 || result !== exps[i]) begin
        testsFailed++;
        $display("[TB] FAIL mulh_%0d: edge %0d result %h, expected edge 34 result %h",
                 i, doneEdge, result, exps[i]);
      end
    end
  endtask

  task automatic test_div_rem();
    logic [4:0]  ops  [4] = '{5'd10, 5'd11, 5'd10, 5'd11};
    logic [31:0] xs   [4] = '{32'd66, 32'd62, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] ys   [4] = '{32'd11, 32'd3, 32'd2, 32'd2};
    logic [31:0] exps [4] = '{32'd6, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    int   doneEdge;
    int   busyCount;
    logic busyAtDone;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue_op(ops[i], xs[i], ys[i]);
      wait_done(40, 0, doneEdge, busyCount, busyAtDone);
      testsRun++;
      if (doneEdge !== 34 || result !== exps[i]) begin
        testsFailed++;
        $display("[TB] FAIL divrem_%0d: edge %0d result %h, expected edge 34 result %h",
                 i, doneEdge, result, exps[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [4:0]  ops  [4] = '{5'd10, 5'd11, 5'd10, 5'd11};
    logic [31:0] xs   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ys   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int   doneEdge;
    int   busyCount;
    logic busyAtDone;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue_op(ops[i], xs[i], ys[i]);
      wait_done(10, 0, doneEdge, busyCount, busyAtDone);
      testsRun++;
      if (doneEdge !== 2 || busyCount !== 1 || result !== exps[i]) begin
        testsFailed++;
        $display("[TB] FAIL special_%0d: edge %0d busy %0d result %h, expected 2 1 %h",
                 i, doneEdge, busyCount, result, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          doneEdge;
    int          doneEdge2;
    int          busyCount;
    logic        busyAtDone;
    logic [31:0] x;
    logic [31:0] y;
    @(negedge clk);
    issue_op(5'd10, 32'd100, 32'd7);
    wait_done(40, 10, doneEdge, busyCount, busyAtDone);
    testsRun++;
    if (doneEdge !== 34 || result !== 32'd14) begin
      testsFailed++;
      $display("[TB] FAIL busy_ignore: edge %0d result %h, expected edge 34 result %h",
               doneEdge, result, 32'd14);
    end
    x = $urandom;
    y = $urandom;
    issue_op(5'd8, x, y);
    wait_done(40, 0, doneEdge2, busyCount, busyAtDone);
    testsRun++;
    if (doneEdge + doneEdge2 !== 68 || result !== ref_model(2'd0, x, y)) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back: edge %0d result %h, expected edge 68 result %h",
               doneEdge + doneEdge2, result, ref_model(2'd0, x, y));
    end
  endtask

  task automatic test_reset_mid_op();
    int   doneEdge;
    int   busyCount;
    logic busyAtDone;
    int   donePulses;
    @(negedge clk);
    issue_op(5'd8, 32'd1234, 32'd5678);
    wait_done(20, 0, doneEdge, busyCount, busyAtDone);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({busy, done} !== 2'b00 || result !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: busy=%b done=%b result=%h, expected 0 0 00000000",
               busy, done, result);
    end
    donePulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0) donePulses++;
    end
    testsRun++;
    if (donePulses !== 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_done: %0d done pulses, expected 0", donePulses);
    end
    rst_n = 1'b1;
    issue_op(5'd8, 32'd2, 32'd3);
    wait_done(40, 0, doneEdge, busyCount, busyAtDone);
    testsRun++;
    if (doneEdge !== 34 || result !== 32'd6) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_mul: edge %0d result %h, expected edge 34 result %h",
               doneEdge, result, 32'd6);
    end
  endtask

  task automatic test_random();
    int          doneEdge;
    int          busyCount;
    logic        busyAtDone;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] expRes;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = MOST_NEG; y = 32'hFFFF_FFFF; end
        2: begin
          x = $urandom_range(0, 200);
          y = $urandom_range(1, 15);
          if ($urandom_range(0, 1) == 1) x = -x;
          if ($urandom_range(0, 1) == 1) y = -y;
        end
        default: ;
      endcase
      expRes = ref_model(op, x, y);
      issue_op({3'b010, op}, x, y);
      wait_done(40, 0, doneEdge, busyCount, busyAtDone);
      testsRun++;
      if (doneEdge !== ref_latency(op, x, y) || result !== expRes) begin
        testsFailed++;
        $display("[TB] FAIL random_%0d op%0d a=%h b=%h: edge %0d result %h, expected %0d %h",
                 i, op, x, y, doneEdge, result, ref_latency(op, x, y), expRes);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        testsRun++;
        if (done !== 1'b0 || result !== expRes) begin
          testsFailed++;
          $display("[TB] FAIL random_hold_%0d: done=%b result=%h, expected 0 %h",
                   i, done, result, expRes);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    alu_opt = 5'd0;
    a       = 32'd0;
    b       = 32'd0;
    test_reset();
    test_invalid_op();
    test_mul_basic();
    test_mulh();
    test_div_rem();
    test_special();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
